ifetch_loader: RTL and testbench
================================

// Module: ifetch_loader
// PURPOSE
//  Parametrised instruction-fetch front end. Owns a word-wide instruction memory, a stream loader
//  that fills it, and a fetch PC. Supersedes the discrete pc + bram32 pairing used for bring-up.
//  Delivers {instr, instr_pc} to decode over a valid/ready handshake, with stall back-pressure,
//  branch/jump redirect and fault reporting.
// PARAMETERS
//  DATA_WIDTH  32   instruction/data word width
//  MEM_DEPTH   1024 instruction memory depth in words (power of 2)
//  BOOT_ADDR   0    byte address loaded into PC on reset and on start
// PORTS
//  clk             in   1            rising-edge clock
//  rst             in   1            asynchronous reset, active-low
//  load_start      in   1            pulse: enter LOAD, clear write pointer
//  load_valid      in   1            load word present
//  load_data       in   DATA_WIDTH   word to store at write pointer
//  load_last       in   1            qualifies final load word
//  load_ready      out  1            loader accepts word
//  run_start       in   1            pulse: PC<=BOOT_ADDR, enter RUN
//  redirect_valid  in   1            taken branch/jump this cycle
//  redirect_pc     in   DATA_WIDTH   redirect target (byte address)
//  instr_valid     out  1            instr/instr_pc valid
//  instr_ready     in   1            decode accepts (low = stall)
//  instr           out  DATA_WIDTH   fetched instruction
//  instr_pc        out  DATA_WIDTH   byte address of instr
//  load_count      out  log2(MEM_DEPTH)+1  words written in last/ongoing load
//  fault           out  1            sticky misaligned/out-of-range/overflow flag
//  state           out  2            IDLE=0 LOAD=1 RUN=2 FAULT=3
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, PC=BOOT_ADDR, instr_valid=0, instr=0,
//   instr_pc=0, load_ready=0, load_count=0, fault=0. Memory contents are not reset.
//  IDLE: load_start -> LOAD; run_start -> RUN. If both are high, load_start wins.
//  LOAD: load_ready=1. On load_valid&&load_ready: mem[load_count]<=load_data, load_count++.
//   - Word accepted with load_last -> IDLE on next edge.
//   - Accept with load_count==MEM_DEPTH-1 and no last -> word stored, fault=1, state FAULT.
//   - run_start is ignored in LOAD.
//  RUN: PC is a byte address; word index = PC[log2(MEM_DEPTH)+1:2].
//   - Sync read, latency 1: address issued at edge N appears on instr after edge N+1.
//     instr_valid rises 1 cycle after entering RUN.
//   - Advance condition: adv = !instr_valid || instr_ready. The read is issued and PC+=4
//     only when adv=1.
//   - When adv=0: instr, instr_pc and PC hold, and the memory read enable is low.
//     No instruction is lost or duplicated.
//   - redirect_valid (priority over adv): the in-flight word is discarded, instr_valid=0
//     next cycle, PC<=redirect_pc. The first redirected word is valid 2 cycles after the
//     redirect cycle.
//   - Fault: redirect_pc[1:0]!=0, or PC>=4*MEM_DEPTH at issue -> fault=1, instr_valid=0,
//     state FAULT, no read issued.
//   - PC+4 wraps modulo 2^DATA_WIDTH. The range check catches it first.
//  FAULT: instr_valid=0, load_ready=0. Only load_start (-> LOAD, fault cleared) or rst exits.
//  load_start in RUN aborts fetch: instr_valid=0 next cycle, -> LOAD.
//  load_count holds after load completes; it is cleared only by load_start.
//  instr_pc always equals the address the valid instr was read from.
// TESTING
//  T1 load 4 words {00500093,00a00113,002081b3,00000013}, last on word 4 -> load_count=4,
//     state=IDLE; run_start -> instr_pc 0,4,8,C with matching instr, one word per cycle.
//  T2 instr_ready=0 for 3 cycles while instr_pc=4 -> instr=00a00113 held 3 cycles,
//     then 8 next; no skip or repeat.
//  T3 redirect_valid with redirect_pc=0 while instr_pc=8 -> instr_valid=0 for 1 cycle,
//     then instr_pc=0, instr=00500093.
//  T4 redirect_pc=6 -> fault=1, state=3, instr_valid=0; load_start -> state=1, fault=0.
//  T5 MEM_DEPTH=4, stream 5 words without last -> 4 stored, fault=1, load_ready=0 on word 5.
//  T6 rst low mid-RUN and mid-LOAD -> all outputs at reset values immediately (async);
//     memory contents retained, run_start re-fetches word 0.

Source files
------------

// File: rtl/ifetch_loader.sv
// Instruction-fetch front end: stream loader fills a word-wide instruction memory, then a fetch
// PC streams {instr, instr_pc} to decode over valid/ready with redirect and sticky fault.
module ifetch_loader #(
  parameter int unsigned             DATA_WIDTH = 32,
  parameter int unsigned             MEM_DEPTH  = 1024,
  parameter logic [DATA_WIDTH-1:0]   BOOT_ADDR  = '0,
  localparam int unsigned            AddrW      = $clog2(MEM_DEPTH),
  localparam int unsigned            CntW       = AddrW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  input  logic                  run_start,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic [CntW-1:0]       load_count,
  output logic                  fault,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StRun   = 2'd2,
    StFault = 2'd3
  } state_e;

  localparam logic [DATA_WIDTH-1:0] MemBytes = DATA_WIDTH'(4 * MEM_DEPTH);
  localparam logic [CntW-1:0]       LastIdx  = CntW'(MEM_DEPTH - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                  instr_valid_q, instr_valid_d;
  logic                  fault_q, fault_d;
  logic [CntW-1:0]       load_count_q, load_count_d;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic             load_fire, adv, redir_bad, pc_oob, in_run;
  logic [AddrW-1:0] rd_idx, wr_idx;

  // load_start takes priority over a word offered in the same cycle
  assign load_fire = (state_q == StLoad) && load_valid && !load_start;
  assign adv       = !instr_valid_q || instr_ready;
  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign pc_oob    = pc_q >= MemBytes;
  assign in_run    = (state_q == StRun) && !load_start;
  assign rd_idx    = pc_q[AddrW+1:2];
  assign wr_idx    = load_count_q[AddrW-1:0];

  // Memory is deliberately not reset so a reload is not needed after rst.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem[wr_idx] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (load_start)     state_d = StLoad;
        else if (run_start) state_d = StRun;
      end
      StLoad: begin
        if (load_fire) begin
          if (load_last)                   state_d = StIdle;
          else if (load_count_q == LastIdx) state_d = StFault;
        end
      end
      StRun: begin
        if (load_start)             state_d = StLoad;
        else if (redirect_valid)    state_d = redir_bad ? StFault : StRun;
        else if (adv && pc_oob)     state_d = StFault;
      end
      StFault: begin
        if (load_start) state_d = StLoad;
      end
    endcase
  end

  always_comb begin
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;
    load_count_d  = load_count_q;

    if (load_start) begin
      load_count_d  = '0;
      fault_d       = 1'b0;
      instr_valid_d = 1'b0;
    end else if (load_fire) begin
      load_count_d = load_count_q + CntW'(1);
      if (!load_last && (load_count_q == LastIdx)) fault_d = 1'b1;
    end

    if ((state_q == StIdle) && run_start && !load_start) begin
      pc_d          = BOOT_ADDR;
      instr_valid_d = 1'b0;
    end

    if (in_run) begin
      if (redirect_valid) begin
        // In-flight word is dropped; the target is issued on the following cycle.
        instr_valid_d = 1'b0;
        if (redir_bad) fault_d = 1'b1;
        else           pc_d    = redirect_pc;
      end else if (adv) begin
        if (pc_oob) begin
          fault_d       = 1'b1;
          instr_valid_d = 1'b0;
        end else begin
          instr_d       = mem[rd_idx];
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + DATA_WIDTH'(4);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= BOOT_ADDR;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      load_count_q  <= '0;
    end else begin
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
      load_count_q  <= load_count_d;
    end
  end

  always_comb begin
    load_ready  = (state_q == StLoad);
    instr_valid = instr_valid_q;
    instr       = instr_q;
    instr_pc    = instr_pc_q;
    load_count  = load_count_q;
    fault       = fault_q;
    state       = state_q;
  end

endmodule

// File: tb/tb_ifetch_loader.sv
// Directed bench for ifetch_loader: a default-size instance for load/fetch/stall/redirect/reset
// and a 4-word instance for load overflow and fetch range fault.
module tb_ifetch_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Default-size DUT
  logic        load_start = 0, load_valid = 0, load_last = 0, run_start = 0;
  logic        redirect_valid = 0, instr_ready = 1;
  logic [31:0] load_data = '0, redirect_pc = '0;
  logic        load_ready, instr_valid, fault;
  logic [31:0] instr, instr_pc;
  logic [10:0] load_count;
  logic [1:0]  state;

  // 4-word DUT
  logic        s_load_start = 0, s_load_valid = 0, s_load_last = 0, s_run_start = 0;
  logic        s_redirect_valid = 0, s_instr_ready = 1;
  logic [31:0] s_load_data = '0, s_redirect_pc = '0;
  logic        s_load_ready, s_instr_valid, s_fault;
  logic [31:0] s_instr, s_instr_pc;
  logic [2:0]  s_load_count;
  logic [1:0]  s_state;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] w [4] = '{32'h00500093, 32'h00a00113, 32'h002081b3, 32'h00000013};

  ifetch_loader u_dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .run_start(run_start),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .load_count(load_count), .fault(fault), .state(state)
  );

  ifetch_loader #(.MEM_DEPTH(4)) u_small (
    .clk(clk), .rst(rst),
    .load_start(s_load_start), .load_valid(s_load_valid), .load_data(s_load_data),
    .load_last(s_load_last), .load_ready(s_load_ready), .run_start(s_run_start),
    .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
    .instr_valid(s_instr_valid), .instr_ready(s_instr_ready), .instr(s_instr),
    .instr_pc(s_instr_pc), .load_count(s_load_count), .fault(s_fault), .state(s_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_fetch(input string tag, input logic [31:0] pc, input logic [31:0] data);
    chk({tag, " valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, " pc"}, instr_pc, pc);
    chk({tag, " instr"}, instr, data);
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst state", {30'd0, state}, 32'd0);
    chk("rst valid", {31'd0, instr_valid}, 32'd0);
    chk("rst instr", instr, 32'd0);
    chk("rst instr_pc", instr_pc, 32'd0);
    chk("rst load_ready", {31'd0, load_ready}, 32'd0);
    chk("rst load_count", {21'd0, load_count}, 32'd0);
    chk("rst fault", {31'd0, fault}, 32'd0);
    step();
    rst = 1'b1;
    step();

    // T5: 4-word memory overflows on the 4th word without last
    s_load_start = 1;
    step();
    s_load_start = 0;
    chk("t5 enter load", {30'd0, s_state}, 32'd1);
    chk("t5 ready", {31'd0, s_load_ready}, 32'd1);
    s_load_valid = 1;
    for (int i = 0; i < 4; i++) begin
      s_load_data = 32'h1111_0000 + i;
      step();
    end
    chk("t5 fault", {31'd0, s_fault}, 32'd1);
    chk("t5 state", {30'd0, s_state}, 32'd3);
    chk("t5 ready off", {31'd0, s_load_ready}, 32'd0);
    chk("t5 count", {29'd0, s_load_count}, 32'd4);
    s_load_data = 32'h1111_0004;
    step();
    chk("t5 5th word dropped", {29'd0, s_load_count}, 32'd4);
    s_load_valid = 0;
    // Reload word 0 only, then fetch to confirm words 1..3 were stored, then range fault
    s_load_start = 1;
    step();
    s_load_start = 0;
    chk("t5 reload fault clr", {31'd0, s_fault}, 32'd0);
    s_load_valid = 1; s_load_last = 1; s_load_data = 32'h1111_0000;
    step();
    s_load_valid = 0; s_load_last = 0;
    chk("t5 reload idle", {30'd0, s_state}, 32'd0);
    s_run_start = 1;
    step();
    s_run_start = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5 fetch pc", s_instr_pc, 32'(4 * i));
      chk("t5 fetch instr", s_instr, 32'h1111_0000 + 32'(i));
    end
    step();
    chk("t5 oob fault", {31'd0, s_fault}, 32'd1);
    chk("t5 oob valid", {31'd0, s_instr_valid}, 32'd0);
    chk("t5 oob state", {30'd0, s_state}, 32'd3);

    // T1: load 4 words
    load_start = 1;
    step();
    load_start = 0;
    chk("t1 load state", {30'd0, state}, 32'd1);
    chk("t1 load_ready", {31'd0, load_ready}, 32'd1);
    load_valid = 1;
    for (int i = 0; i < 4; i++) begin
      load_data = w[i];
      load_last = (i == 3);
      step();
    end
    load_valid = 0; load_last = 0;
    chk("t1 load_count", {21'd0, load_count}, 32'd4);
    chk("t1 idle", {30'd0, state}, 32'd0);
    run_start = 1;
    step();
    run_start = 0;
    chk("t1 run state", {30'd0, state}, 32'd2);
    chk("t1 first cycle invalid", {31'd0, instr_valid}, 32'd0);
    step();
    chk_fetch("t1 w0", 32'h0, w[0]);
    step();
    chk_fetch("t1 w1", 32'h4, w[1]);

    // T2: stall 3 cycles at instr_pc=4
    instr_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_fetch("t2 hold", 32'h4, w[1]);
    end
    instr_ready = 1;
    step();
    chk_fetch("t2 resume", 32'h8, w[2]);

    // T3: redirect to 0 while instr_pc=8
    redirect_valid = 1; redirect_pc = 32'h0;
    step();
    redirect_valid = 0;
    chk("t3 bubble", {31'd0, instr_valid}, 32'd0);
    step();
    chk_fetch("t3 target", 32'h0, w[0]);
    step();
    chk_fetch("t3 w1", 32'h4, w[1]);
    step();
    chk_fetch("t3 w2", 32'h8, w[2]);
    step();
    chk_fetch("t1 w3", 32'hC, w[3]);

    // T4: misaligned redirect
    redirect_valid = 1; redirect_pc = 32'h6;
    step();
    redirect_valid = 0;
    chk("t4 fault", {31'd0, fault}, 32'd1);
    chk("t4 state", {30'd0, state}, 32'd3);
    chk("t4 valid", {31'd0, instr_valid}, 32'd0);
    step();
    chk("t4 sticky", {31'd0, fault}, 32'd1);
    load_start = 1;
    step();
    load_start = 0;
    chk("t4 exit state", {30'd0, state}, 32'd1);
    chk("t4 fault clr", {31'd0, fault}, 32'd0);

    // T6: async reset mid-LOAD (rewrite word 0 with same value so memory stays known)
    load_valid = 1; load_data = w[0];
    step();
    load_valid = 0;
    chk("t6 count before rst", {21'd0, load_count}, 32'd1);
    #1 rst = 0;
    #1;
    chk("t6 load rst state", {30'd0, state}, 32'd0);
    chk("t6 load rst count", {21'd0, load_count}, 32'd0);
    chk("t6 load rst ready", {31'd0, load_ready}, 32'd0);
    step();
    rst = 1;
    run_start = 1;
    step();
    run_start = 0;
    step();
    chk_fetch("t6 refetch w0", 32'h0, w[0]);
    step();
    chk_fetch("t6 refetch w1", 32'h4, w[1]);
    // mid-RUN reset
    #1 rst = 0;
    #1;
    chk("t6 run rst valid", {31'd0, instr_valid}, 32'd0);
    chk("t6 run rst instr", instr, 32'd0);
    chk("t6 run rst pc", instr_pc, 32'd0);
    chk("t6 run rst state", {30'd0, state}, 32'd0);
    step();
    rst = 1;
    run_start = 1;
    step();
    run_start = 0;
    step();
    chk_fetch("t6 after run rst", 32'h0, w[0]);

    // load_start during RUN aborts fetch
    load_start = 1;
    step();
    load_start = 0;
    chk("abort valid", {31'd0, instr_valid}, 32'd0);
    chk("abort state", {30'd0, state}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
